// File: rtl/iv_load_sequencer.sv
// Round-robin front end for a shared passive-serial FPGA loader with retry and hang detection.
// Optional job statistics counters are enabled with `define IV_LOAD_SEQ_STATS_EN.
module iv_load_sequencer #(
  parameter int N_REQ          = 2,
  parameter int MEM_AW         = 11,
  parameter int MAX_RETRY      = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*MEM_AW-1:0]         req_addr,
  output logic [N_REQ-1:0]                req_done,
  output logic [N_REQ-1:0]                req_fail,
  output logic                            busy,
  output logic                            hung,
  output logic                            ld_start,
  output logic [MEM_AW-1:0]               ld_start_addr,
  input  logic                            ld_ready,
  input  logic                            ld_error,
  output logic [$clog2(MAX_RETRY+2)-1:0]  attempt,
  output logic [15:0]                     ok_count,
  output logic [15:0]                     err_count
);

  localparam int AW = $clog2(MAX_RETRY + 2);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [AW-1:0] LAST_ATTEMPT = AW'(MAX_RETRY);
  localparam logic [TW-1:0] LAST_TICK    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] LAST_GAP     = GW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_GAP       = 3'd2;
  localparam logic [2:0] S_DONE_OK   = 3'd3;
  localparam logic [2:0] S_DONE_FAIL = 3'd4;
  localparam logic [2:0] S_HUNG      = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] grant;
  logic [PW-1:0] ptr;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [PW-1:0] pick;
  logic          any_req;
  logic          run_hang;
  int            idx;

  // First requester at or after the pointer, scanning with wrap-around.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = PW'(idx);
      end
    end
  end

  assign ld_start = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign run_hang = (state == S_RUN) && !ld_ready && (tcnt == LAST_TICK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      grant         <= '0;
      ptr           <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      attempt       <= '0;
      ld_start_addr <= '0;
      req_done      <= '0;
      req_fail      <= '0;
      hung          <= 1'b0;
    end else begin
      req_done <= '0;
      req_fail <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant         <= pick;
            ptr           <= (int'(pick) == N_REQ - 1) ? '0 : pick + PW'(1);
            ld_start_addr <= req_addr[int'(pick)*MEM_AW +: MEM_AW];
            attempt       <= '0;
            tcnt          <= '0;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (ld_ready) begin
            if (!ld_error) begin
              req_done[grant] <= 1'b1;
              state           <= S_DONE_OK;
            end else if (attempt == LAST_ATTEMPT) begin
              req_done[grant] <= 1'b1;
              req_fail[grant] <= 1'b1;
              state           <= S_DONE_FAIL;
            end else begin
              attempt <= attempt + AW'(1);
              gcnt    <= '0;
              state   <= S_GAP;
            end
          end else if (run_hang) begin
            req_done[grant] <= 1'b1;
            req_fail[grant] <= 1'b1;
            hung            <= 1'b1;
            state           <= S_HUNG;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_GAP: begin
          if (gcnt == LAST_GAP) begin
            tcnt  <= '0;
            state <= S_RUN;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        S_DONE_OK, S_DONE_FAIL: state <= S_IDLE;
        // The loader must signal ready before a hung job is released.
        S_HUNG: if (ld_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IV_LOAD_SEQ_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ok_count  <= '0;
      err_count <= '0;
    end else begin
      if ((state == S_DONE_OK) && (ok_count != 16'hFFFF))
        ok_count <= ok_count + 16'd1;
      if (((state == S_DONE_FAIL) || run_hang) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end
`else
  assign ok_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_iv_load_sequencer.sv
// Self-checking bench: table-driven directed jobs, timeout/reset corner cases and randomized jobs
// checked against a transaction-level round-robin/retry model.
module tb_iv_load_sequencer;

  localparam int N    = 2;
  localparam int AW   = 11;
  localparam int MAXR = 2;
  localparam int GAP  = 16;
  localparam int TMO  = 100;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_done;
  logic [N-1:0]      req_fail;
  logic              busy;
  logic              hung;
  logic              ld_start;
  logic [AW-1:0]     ld_start_addr;
  logic              ld_ready;
  logic              ld_error;
  logic [1:0]        attempt;
  logic [15:0]       ok_count;
  logic [15:0]       err_count;

  typedef struct {
    logic [N-1:0]  reqv;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    int            nerr;
    int            dly;
    int            exp_g;
  } vec_t;

  vec_t tbl [9];

  int n_tests  = 0;
  int n_fail   = 0;
  int rr_ptr   = 0;
  int ok_exp   = 0;
  int err_exp  = 0;
  bit hung_exp = 1'b0;

  iv_load_sequencer #(
    .N_REQ(N), .MEM_AW(AW), .MAX_RETRY(MAXR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr),
    .req_done(req_done), .req_fail(req_fail), .busy(busy), .hung(hung),
    .ld_start(ld_start), .ld_start_addr(ld_start_addr),
    .ld_ready(ld_ready), .ld_error(ld_error), .attempt(attempt),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-robin expressed as "smallest rotated distance from the pointer".
  function automatic int model_grant(input logic [N-1:0] r);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++)
      if (r[i] && ((i - rr_ptr + N) % N) < bestd) begin
        bestd = (i - rr_ptr + N) % N;
        best  = i;
      end
    return best;
  endfunction

  task automatic check_stats(input string name);
`ifdef IV_LOAD_SEQ_STATS_EN
    checkOutput({name, ".ok_count"}, 32'(ok_count), ok_exp);
    checkOutput({name, ".err_count"}, 32'(err_count), err_exp);
`else
    checkOutput({name, ".ok_count"}, 32'(ok_count), 0);
    checkOutput({name, ".err_count"}, 32'(err_count), 0);
`endif
  endtask

  task automatic wait_start(input string name, output int cycles);
    cycles = 0;
    while (!ld_start && cycles < 60) begin
      @(negedge clock);
      cycles++;
    end
    if (!ld_start) checkOutput({name, ".start_wait"}, 32'(ld_start), 1);
  endtask

  // One complete job: nerr leading loader errors, then success (or failure once retries run out).
  task automatic applyStimulus(input string name, input logic [N-1:0] reqv,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input int nerr, input int dly, input int exp_g);
    int cyc;
    int n_att;
    int d;
    bit fail;
    logic [AW-1:0] exp_addr;
    req_addr = {a1, a0};
    req      = reqv;
    exp_addr = (exp_g == 0) ? a0 : a1;
    fail     = (nerr > MAXR);
    n_att    = fail ? MAXR + 1 : nerr + 1;
    for (int a = 0; a < n_att; a++) begin
      wait_start(name, cyc);
      if (a == 0) checkOutput({name, ".latency"}, cyc, 1);
      checkOutput({name, ".addr"}, 32'(ld_start_addr), 32'(exp_addr));
      checkOutput({name, ".attempt"}, 32'(attempt), a);
      d = (dly > 0) ? dly : int'($urandom_range(6, 1));
      repeat (d) @(negedge clock);
      checkOutput({name, ".start_held"}, 32'(ld_start), 1);
      ld_ready = 1'b1;
      ld_error = (a < nerr);
      @(negedge clock);
      ld_ready = 1'b0;
      ld_error = 1'b0;
      checkOutput({name, ".start_drop"}, 32'(ld_start), 0);
      if (a < n_att - 1) begin
        checkOutput({name, ".gap_done"}, 32'(req_done), 0);
        cyc = 0;
        while (!ld_start && cyc < 100) begin
          cyc++;
          @(negedge clock);
        end
        checkOutput({name, ".gap_len"}, cyc, GAP);
      end
    end
    checkOutput({name, ".done"}, 32'(req_done), 32'(1) << exp_g);
    checkOutput({name, ".fail"}, 32'(req_fail), fail ? (32'(1) << exp_g) : 0);
    checkOutput({name, ".busy_done"}, 32'(busy), 1);
    if (fail) err_exp++; else ok_exp++;
    rr_ptr = (exp_g + 1) % N;
    @(negedge clock);
    checkOutput({name, ".done_once"}, 32'(req_done), 0);
    checkOutput({name, ".idle"}, 32'(busy), 0);
    checkOutput({name, ".hung"}, 32'(hung), 32'(hung_exp));
    check_stats(name);
  endtask

  // Loader never answers: expect timeout, fail pulse, HUNG until ready, sticky hung flag.
  task automatic apply_hang(input string name, input logic [N-1:0] reqv,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1, input int exp_g);
    int cyc;
    req_addr = {a1, a0};
    req      = reqv;
    wait_start(name, cyc);
    checkOutput({name, ".latency"}, cyc, 1);
    checkOutput({name, ".addr"}, 32'(ld_start_addr), (exp_g == 0) ? 32'(a0) : 32'(a1));
    cyc = 0;
    while (ld_start && cyc < 300) begin
      cyc++;
      @(negedge clock);
    end
    checkOutput({name, ".high_cycles"}, cyc, TMO);
    checkOutput({name, ".hung"}, 32'(hung), 1);
    checkOutput({name, ".done"}, 32'(req_done), 32'(1) << exp_g);
    checkOutput({name, ".fail"}, 32'(req_fail), 32'(1) << exp_g);
    hung_exp = 1'b1;
    err_exp++;
    rr_ptr = (exp_g + 1) % N;
    req = '0;
    repeat (5) @(negedge clock);
    checkOutput({name, ".busy_stuck"}, 32'(busy), 1);
    checkOutput({name, ".start_low"}, 32'(ld_start), 0);
    checkOutput({name, ".done_once"}, 32'(req_done), 0);
    ld_ready = 1'b1;
    @(negedge clock);
    ld_ready = 1'b0;
    checkOutput({name, ".released"}, 32'(busy), 0);
    checkOutput({name, ".hung_sticky"}, 32'(hung), 1);
    check_stats(name);
  endtask

  initial begin
    int seen;
    logic [N-1:0]  rq;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;

    tbl[0] = '{2'b01, 11'h040, 11'h111, 0, 5, 0};
    tbl[1] = '{2'b11, 11'h040, 11'h2A5, 0, 3, 1};
    tbl[2] = '{2'b11, 11'h040, 11'h2A5, 0, 3, 0};
    tbl[3] = '{2'b11, 11'h040, 11'h2A5, 0, 3, 1};
    tbl[4] = '{2'b11, 11'h040, 11'h2A5, 0, 3, 0};
    tbl[5] = '{2'b10, 11'h123, 11'h456, 2, 2, 1};
    tbl[6] = '{2'b01, 11'h7FF, 11'h001, 3, 1, 0};
    tbl[7] = '{2'b01, 11'h300, 11'h030, 1, 7, 0};
    tbl[8] = '{2'b11, 11'h0AA, 11'h555, 0, 4, 1};

    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    ld_ready = 1'b0;
    ld_error = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset.busy", 32'(busy), 0);
    checkOutput("reset.ld_start", 32'(ld_start), 0);
    checkOutput("reset.hung", 32'(hung), 0);
    checkOutput("reset.done", 32'(req_done), 0);
    checkOutput("reset.attempt", 32'(attempt), 0);
    checkOutput("reset.addr", 32'(ld_start_addr), 0);
    check_stats("reset");

    for (int i = 0; i < 9; i++)
      applyStimulus($sformatf("tbl%0d", i), tbl[i].reqv, tbl[i].a0, tbl[i].a1,
                    tbl[i].nerr, tbl[i].dly, tbl[i].exp_g);

    apply_hang("hang", 2'b11, 11'h0F0, 11'h00F, 0);

    for (int i = 0; i < 25; i++) begin
      rq  = N'($urandom_range(3, 1));
      ra0 = AW'($urandom);
      ra1 = ra0 ^ AW'($urandom_range(2047, 1));
      applyStimulus($sformatf("rnd%0d", i), rq, ra0, ra1, int'($urandom_range(3, 0)), 0,
                    model_grant(rq));
    end

    // Asynchronous reset in the middle of an attempt.
    req_addr = {11'h222, 11'h111};
    req      = 2'b01;
    wait_start("midreset", seen);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset.ld_start", 32'(ld_start), 0);
    checkOutput("midreset.busy", 32'(busy), 0);
    checkOutput("midreset.hung", 32'(hung), 0);
    req = '0;
    @(negedge clock);
    reset    = 1'b0;
    rr_ptr   = 0;
    ok_exp   = 0;
    err_exp  = 0;
    hung_exp = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (req_done != '0) seen++;
    end
    checkOutput("midreset.no_done", seen, 0);
    applyStimulus("after_reset", 2'b11, 11'h333, 11'h444, 1, 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iv_load_sequencer.md
Name: iv_load_sequencer

Overview:
- Shares one FPGA passive-serial loader (start/ready/error handshake plus start address) between N_REQ requesters, e.g. host register bank and power-on auto-boot.
- Round-robin arbitration, latches the winner's image address, retries failed configurations and detects hung loads by timeout.
- Sits directly in front of the loader; one request is in flight at a time.

Parameters:
- N_REQ, 2, number of requesters (≥1).
- MEM_AW, 11, loader start-address width.
- MAX_RETRY, 2, extra attempts after a failed attempt (total attempts = 1+MAX_RETRY).
- GAP_CYCLES, 16, cycles ld_start is held low between attempts (≥1).
- TIMEOUT_CYCLES, 1000000, max cycles of one attempt with ld_start high.

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request per requester
- req_addr  in  N_REQ*MEM_AW  image start address; slice i belongs to requester i
- req_done  out  N_REQ  one-cycle pulse when requester i's job ends
- req_fail  out  N_REQ  pulses with req_done[i] if the job failed
- busy  out  1  high whenever not in IDLE
- hung  out  1  sticky timeout flag, cleared only by reset
- ld_start  out  1  loader start, level
- ld_start_addr  out  MEM_AW  latched address of the granted job
- ld_ready  in  1  loader ready
- ld_error  in  1  loader error
- attempt  out  2+  attempt index of the current job, 0-based; width $clog2(MAX_RETRY+2)
- ok_count  out  16  successful jobs (optional feature)
- err_count  out  16  failed jobs (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; hung 0.
- Loader handshake:
  - ld_start rises, then is held high until ld_ready==1 is sampled while ld_start is high. This marks completion, since the loader drives ready low combinationally while start is high outside its finished state.
  - ld_error is sampled in that same cycle.
  - ld_start drops the following cycle.
- States:
  - IDLE: if any req bit is set, grant the first set bit at or after the pointer (wrap at N_REQ). Latch ld_start_addr from that slice, set attempt=0, go to RUN. Pointer = grant+1 mod N_REQ.
  - RUN: ld_start=1; timeout counter increments.
    - ld_ready & !ld_error: go to DONE_OK.
    - ld_ready & ld_error & attempt<MAX_RETRY: attempt++, go to GAP.
    - ld_ready & ld_error & attempt==MAX_RETRY: go to DONE_FAIL.
    - Counter reaches TIMEOUT_CYCLES-1 without ld_ready: set hung, go to HUNG.
  - GAP: ld_start=0 for GAP_CYCLES cycles, then RUN. Address is unchanged.
  - DONE_OK / DONE_FAIL: one cycle. Pulse req_done[grant]; DONE_FAIL also pulses req_fail[grant]. Then IDLE.
  - HUNG: ld_start=0 and req_fail[grant]+req_done[grant] pulse on entry. Stay until ld_ready==1 is sampled, then IDLE. hung stays set.
- Latency: req rises in cycle 0, ld_start is high in cycle 1 (registered). Completion at cycle k gives req_done at cycle k+1.
- req is level-sampled only in IDLE. Dropping req mid-job does not abort it. If req is still high when back in IDLE, it counts as a new request.
- Simultaneous requests are served strictly in pointer order; no starvation; each requester waits at most N_REQ-1 jobs.
- ld_start_addr and the grant index are stable for the whole job, including retries.
- Asynchronous reset mid-job returns to IDLE at once with ld_start=0. No done pulse is issued.
- ld_ready is ignored outside RUN and HUNG.

Optional Feature:
- Macro: IV_LOAD_SEQ_STATS_EN.
- Defined: ok_count increments on DONE_OK. err_count increments on DONE_FAIL and on HUNG entry. Both saturate at 16'hFFFF and reset to 0.
- Undefined: no counter registers; ok_count and err_count are tied to 0.

Test Plan:
- req=01, addr0=0x040; loader model asserts ready with error=0 five cycles after start → ld_start high at cycle 1, ld_start_addr=0x040, req_done=01 once, req_fail=00, ok_count=1.
- req=11 held continuously → grants alternate 0,1,0,1. Each req_done pulse matches its grant; ld_start_addr switches between the two addresses.
- Model returns error on the first two attempts, OK on the third (MAX_RETRY=2) → attempt goes 0,1,2; ld_start is low exactly 16 cycles between attempts; req_done pulses without req_fail.
- Model always errors → three attempts, then req_done and req_fail pulse together; err_count=1; attempt was never >2.
- Model never asserts ready (TIMEOUT_CYCLES=100) → ld_start drops after 100 high cycles, hung=1, fail pulse; sequencer stays busy until ready is later asserted, then IDLE; hung stays 1.
- reset asserted mid-RUN → ld_start=0 and busy=0 asynchronously; no done pulse; a fresh req afterwards is served normally.
